// File: rtl/logger_pkg.sv
// Shared definitions for the logger datapath: sequencer FSM encoding and
// limits on the serial-clock divider.
package logger_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      SHIFT   = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam int DEFAULT_DATA_W = 16;
   localparam int SCLK_DIV_MIN   = 4;
   localparam int SCLK_DIV_MAX   = 255;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for one edge-detected line plus PASS_W plain lines;
// rise is a registered one-clk pulse on a synchronised 0->1 of edge_in.
module sync_edge_det #(
   parameter int PASS_W = 1
) (
   input  logic              clk,
   input  logic              res,
   input  logic              edge_in,
   input  logic [PASS_W-1:0] pass_in,
   output logic              rise,
   output logic [PASS_W-1:0] pass_sync
);

   logic [PASS_W:0] meta_reg;
   logic [PASS_W:0] sync_reg;
   logic            rise_reg;

   always_ff @(posedge clk) begin
      if (res) begin
         meta_reg <= '0;
         sync_reg <= '0;
         rise_reg <= 1'b0;
      end else begin
         meta_reg <= {pass_in, edge_in};
         sync_reg <= meta_reg;
         // Pulse lands on the same clk the synchronised level turns high
         rise_reg <= meta_reg[0] & ~sync_reg[0];
      end
   end

   assign rise      = rise_reg;
   assign pass_sync = sync_reg[PASS_W:1];

endmodule

// File: rtl/adc_read_sequencer.sv
// Reads one serial ADC word per nDRDY rising edge and hands it downstream
// over a valid/ready handshake; flags completion after NUM_SAMPLES words.
module adc_read_sequencer
   import logger_pkg::*;
#(
   parameter int DATA_W      = DEFAULT_DATA_W,
   parameter int SCLK_DIV    = 4,
   parameter int NUM_SAMPLES = 1024,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              res,
   input  logic              start_pulse,
   input  logic              nDRDY,
   input  logic              SDIN1,
   output logic              SCLK1,
   output logic [DATA_W-1:0] sample_data,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              busy,
   output logic              data_done,
   output logic              overrun,
   output logic [CNT_W-1:0]  sample_cnt
);

   localparam int DIV = (SCLK_DIV < SCLK_DIV_MIN) ? SCLK_DIV_MIN :
                        (SCLK_DIV > SCLK_DIV_MAX) ? SCLK_DIV_MAX : SCLK_DIV;
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [7:0]       DIV_LAST = 8'(DIV - 1);
   localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] NUM_C    = CNT_W'(NUM_SAMPLES);

   state_t             state_reg;
   logic               sclk_reg;
   logic [7:0]         div_reg;
   logic [BIT_W-1:0]   bit_reg;
   logic [DATA_W-1:0]  shreg;
   logic [DATA_W-1:0]  data_reg;
   logic               valid_reg;
   logic               overrun_reg;
   logic [CNT_W-1:0]   cnt_reg;

   logic               drdy_edge;
   logic               sdin_sync;
   logic               load;
   logic [CNT_W-1:0]   cnt_next;

   sync_edge_det #(
      .PASS_W (1)
   ) u_sync (
      .clk       (clk),
      .res       (res),
      .edge_in   (nDRDY),
      .pass_in   (SDIN1),
      .rise      (drdy_edge),
      .pass_sync (sdin_sync)
   );

   // A word is accepted when the output register is empty or being drained this clk
   assign load     = !valid_reg || sample_ready;
   assign cnt_next = (load && cnt_reg != NUM_C) ? cnt_reg + CNT_W'(1) : cnt_reg;

   always_ff @(posedge clk) begin
      if (res) begin
         state_reg   <= IDLE;
         sclk_reg    <= 1'b0;
         div_reg     <= '0;
         bit_reg     <= '0;
         shreg       <= '0;
         data_reg    <= '0;
         valid_reg   <= 1'b0;
         overrun_reg <= 1'b0;
         cnt_reg     <= '0;
      end else begin
         if (valid_reg && sample_ready)
            valid_reg <= 1'b0;

         case (state_reg)
            IDLE, DONE: begin
               if (start_pulse) begin
                  state_reg   <= ARMED;
                  cnt_reg     <= '0;
                  overrun_reg <= 1'b0;
               end
            end
            ARMED: begin
               if (drdy_edge) begin
                  state_reg <= SHIFT;
                  bit_reg   <= BIT_TOP;
                  div_reg   <= '0;
                  sclk_reg  <= 1'b1;
               end
            end
            SHIFT: begin
               if (drdy_edge)
                  overrun_reg <= 1'b1;
               if (div_reg == DIV_LAST) begin
                  div_reg <= '0;
                  if (sclk_reg) begin
                     shreg    <= {shreg[DATA_W-2:0], sdin_sync};
                     sclk_reg <= 1'b0;
                  end else if (bit_reg == '0) begin
                     state_reg <= CAPTURE;
                  end else begin
                     bit_reg  <= bit_reg - BIT_W'(1);
                     sclk_reg <= 1'b1;
                  end
               end else begin
                  div_reg <= div_reg + 8'd1;
               end
            end
            CAPTURE: begin
               if (drdy_edge)
                  overrun_reg <= 1'b1;
               if (load) begin
                  data_reg  <= shreg;
                  valid_reg <= 1'b1;
               end else begin
                  overrun_reg <= 1'b1;
               end
               cnt_reg   <= cnt_next;
               state_reg <= (cnt_next == NUM_C) ? DONE : ARMED;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign SCLK1        = sclk_reg;
   assign sample_data  = data_reg;
   assign sample_valid = valid_reg;
   assign overrun      = overrun_reg;
   assign sample_cnt   = cnt_reg;
   assign busy         = (state_reg == ARMED) || (state_reg == SHIFT) || (state_reg == CAPTURE);
   assign data_done    = (state_reg == DONE);

endmodule
